div_responder: RTL and testbench
================================

Name: div_responder

Overview:
- Iterative multi-cycle integer divider serving the ALU's start/ready divide handshake.
- Sits beside the execute-stage ALU. The ALU raises start with its operands and holds them stable while stalled; this block returns {remainder, quotient} with a ready indication.
- Supports the signed and unsigned 32-bit divides (DIV/DIVU). It produces results shaped for direct write into HI/LO: HI = remainder, LO = quotient.

Parameters:
DATA_W, 32, operand width; quotient and remainder are each DATA_W bits, result_o is 2*DATA_W.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
signed_div_i  input  1  1 = signed divide, 0 = unsigned; sampled with start_i in IDLE
opdata1_i  input  DATA_W  dividend
opdata2_i  input  DATA_W  divisor
start_i  input  1  request; initiator holds high until it sees ready_o, then drops it in the same cycle
annul_i  input  1  abort in-flight divide
result_o  output  2*DATA_W  {remainder, quotient}
ready_o  output  1  result_o valid

Behaviour:
- Reset (rst=0, async): state=IDLE, result_o=0, ready_o=0, all internal registers cleared. Reset mid-divide discards the operation; no ready is produced.
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE: ready_o=0.
  - On an edge with start_i=1 and annul_i=0, capture signed_div_i, opdata1_i and opdata2_i into internal registers.
  - For signed operations, registers hold magnitudes; signs are kept separately.
  - Divisor==0 -> DIVZERO; otherwise -> BUSY with iteration counter=0.
- Operand changes after capture are ignored until the block returns to IDLE.
- DIVZERO: one cycle, then -> DONE.
  - Quotient = all-ones; remainder = opdata1 as captured (raw, not magnitude).
- BUSY: one restoring-division step per cycle.
  - Shift {partial remainder, dividend} left by 1; trial-subtract |divisor|.
  - If no borrow, keep the difference and shift in quotient bit 1; else shift in 0.
  - After DATA_W steps -> DONE.
- Sign fix-up on entry to DONE (signed only):
  - Quotient is negated if dividend sign XOR divisor sign.
  - Remainder is negated if dividend is negative.
  - Fix-up is applied while registering result_o, so it adds no extra cycle.
- DONE: ready_o=1, result_o holds the result.
  - start_i=0 -> IDLE at the next edge; ready_o is a one-cycle pulse with the standard initiator.
  - start_i still 1 -> remain in DONE, ready_o held high. No restart until start_i drops.
- Latency: start_i sampled at edge E0.
  - Normal divide: ready_o high in the cycle after edge E(DATA_W+1), i.e. 33 cycles after E0 for DATA_W=32.
  - Divide-by-zero: ready_o high after E2.
- annul_i=1 in DIVZERO or BUSY -> IDLE at the next edge; ready_o stays 0 and result_o is unchanged.
  - annul_i in IDLE blocks a start.
  - annul_i in DONE is ignored.
- result_o keeps the last completed value until the next completion or reset.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This falls out of the magnitude arithmetic and raises no exception.
- All width arithmetic uses DATA_W+1 bits for the trial subtract. Magnitude of 0x80000000 is 0x80000000 as an unsigned value.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - On capture, count leading zeros n of |dividend|, using the combinational priority count.
  - Pre-shift the dividend left by n; run DATA_W-n steps, minimum 1 step.
  - Dividend 0 runs 1 step.
  - Normal-divide latency becomes (DATA_W-n)+1 cycles from E0 to ready_o. Results are identical.
- Undefined: fixed DATA_W steps as above.

Test Plan:
- Unsigned 100 / 7, signed_div_i=0, start held until ready -> ready_o pulses exactly once, at cycle 33 after E0; result_o={32'd2, 32'd14}. Next cycle ready_o=0, state IDLE.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Then 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero, 0x12345678 / 0 -> ready_o at cycle 2 after E0; result_o={0x12345678, 0xFFFFFFFF}.
- Signed 0x80000000 / 0xFFFFFFFF -> result_o={0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- Three interrupted divides:
  - annul_i=1 at BUSY cycle 10 -> no ready; IDLE next cycle; a new start then yields a correct result.
  - rst=0 asserted mid-BUSY -> ready_o=0 and result_o=0 immediately, without waiting for a clock edge.
  - Operands changed mid-BUSY -> result reflects the captured values.
- Hold start_i=1 in DONE for 3 cycles -> ready_o stays 1 for 3 cycles with stable result_o, then IDLE after start drops. With DIV_EARLY_EXIT_EN: 7 / 2 unsigned -> ready at cycle 4 after E0, result {1, 3}.

Source files
------------

// File: rtl/div_responder.sv
// Iterative restoring divider (DIV/DIVU) returning {remainder, quotient} over a start/ready handshake.
// Optional build macro DIV_EARLY_EXIT_EN skips leading-zero iterations of the dividend magnitude.
module div_responder #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIVZERO = 2'd1;
  localparam logic [1:0] BUSY    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   dvd_mag, dvs_mag;
  logic [DATA_W:0]     rem_shift, diff;
  logic [DATA_W-1:0]   rem_step, quo_step;

  assign dvd_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign dvs_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Partial remainder stays below the divisor, so bit DATA_W of the trial difference is the borrow.
  assign rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign rem_step  = diff[DATA_W] ? rem_shift[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_step  = {quo_q[DATA_W-2:0], ~diff[DATA_W]};

`ifdef DIV_EARLY_EXIT_EN
  logic [CNT_W-1:0] lz;

  always_comb begin
    lz = CNT_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (dvd_mag[i]) lz = CNT_W'(DATA_W - 1 - i);
    end
  end
`endif

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          neg_quo_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d = signed_div_i && opdata1_i[DATA_W-1];
          dvs_d     = dvs_mag;
          rem_d     = '0;
          if (opdata2_i == '0) begin
            quo_d   = opdata1_i;
            state_d = DIVZERO;
          end else begin
`ifdef DIV_EARLY_EXIT_EN
            quo_d = dvd_mag << lz;
            cnt_d = (lz == CNT_W'(DATA_W)) ? CNT_W'(1) : CNT_W'(DATA_W) - lz;
`else
            quo_d = dvd_mag;
            cnt_d = CNT_W'(DATA_W);
`endif
            state_d = BUSY;
          end
        end
      end
      DIVZERO: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          result_d = {quo_q, {DATA_W{1'b1}}};
          state_d  = DONE;
        end
      end
      BUSY: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_d = {neg_rem_q ? -rem_step : rem_step,
                        neg_quo_q ? -quo_step : quo_step};
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        // Stay until ready has been shown and the initiator has released start.
        if (!start_i && ready_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_q == DONE) && (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_responder.sv
// Self-checking bench for div_responder: directed cases plus randomized divides against an arithmetic model.
// Honours DIV_EARLY_EXIT_EN for the expected latency.
module tb_div_responder;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              signed_div_i;
  logic [DATA_W-1:0] opdata1_i, opdata2_i;
  logic              start_i, annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic              ready_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_res = '0;

  div_responder #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer division in 64-bit arithmetic (truncating, remainder follows dividend).
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    la = sgn ? longint'(signed'(a)) : longint'({32'b0, a});
    lb = sgn ? longint'(signed'(b)) : longint'({32'b0, b});
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag;
    int bits;
    if (b == 0) return 2;
    mag  = (sgn && a[31]) ? 32'(-a) : a;
    bits = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
`ifdef DIV_EARLY_EXIT_EN
    return ((bits == 0) ? 1 : bits) + 1;
`else
    return DATA_W + 1;
`endif
  endfunction

  // Issue a divide, wait for ready, check latency/result, optionally hold start in DONE,
  // optionally scramble the operands chg_at cycles after capture.
  task automatic run_div(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input int chg_at);
    logic [63:0] exp;
    int lat, k;
    bit got;
    exp = ref_div(sgn, a, b);
    lat = ref_lat(sgn, a, b);
    signed_div_i = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    cyc();
    k = 0;
    got = 0;
    while (k < 100 && !got) begin
      cyc();
      k++;
      if (ready_o) got = 1;
      else if (k == chg_at) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~signed_div_i;
      end
    end
    check({tag, "_lat"}, 64'(k), 64'(lat));
    check({tag, "_res"}, result_o, exp);
    last_res = exp;
    for (int h = 0; h < hold; h++) begin
      cyc();
      check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
      check({tag, "_hold_res"}, result_o, exp);
    end
    start_i = 1'b0;
    cyc();
    check({tag, "_rdy_drop"}, 64'(ready_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    #1;
    check("reset_rdy", 64'(ready_o), 64'd0);
    check("reset_res", result_o, 64'd0);
    #11 rst = 1'b1;
    cyc();

    run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, 0, 0);
    cyc();
    check("idle_after_pulse", 64'(ready_o), 64'd0);
    run_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_div("divzero", 1'b0, 32'h1234_5678, 32'd0, 0, 0);
    run_div("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_div("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);
    run_div("hold3", 1'b0, 32'd1000, 32'd10, 3, 0);
    run_div("udiv_7_2", 1'b0, 32'd7, 32'd2, 0, 0);
    run_div("dvd_zero", 1'b1, 32'd0, 32'd5, 0, 0);

    // Annul at BUSY cycle 10: no ready, result untouched, then a clean divide.
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    cyc();
    repeat (10) cyc();
    annul_i = 1'b1; start_i = 1'b0;
    cyc();
    annul_i = 1'b0;
    check("annul_rdy", 64'(ready_o), 64'd0);
    check("annul_res", result_o, last_res);
    begin
      bit seen = 0;
      repeat (40) begin cyc(); if (ready_o) seen = 1; end
      check("annul_no_ready", 64'(seen), 64'd0);
    end
    run_div("after_annul", 1'b0, 32'd1000, 32'd3, 0, 0);

    // Annul in IDLE blocks a start.
    opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    repeat (3) cyc();
    start_i = 1'b0; annul_i = 1'b0;
    begin
      bit seen = 0;
      repeat (40) begin cyc(); if (ready_o) seen = 1; end
      check("idle_annul_no_ready", 64'(seen), 64'd0);
    end

    // Async reset mid-BUSY clears outputs without a clock edge.
    opdata1_i = 32'd999; opdata2_i = 32'd4; start_i = 1'b1;
    cyc();
    repeat (5) cyc();
    start_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_rdy", 64'(ready_o), 64'd0);
    check("midrst_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    last_res = '0;
    begin
      bit seen = 0;
      repeat (40) begin cyc(); if (ready_o) seen = 1; end
      check("midrst_no_ready", 64'(seen), 64'd0);
    end

    run_div("chg_mid", 1'b1, 32'hFFFF_0123, 32'd77, 0, 5);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      int sel;
      a = $urandom;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) b = '0;
      else if (sel < 3) b = $urandom_range(1, 15);
      else if (sel == 3) b = 32'hFFFF_FFFF;
      else b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 9) == 0) a = a >> 28;
      run_div("rand", 1'($urandom), a, b, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
